// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and frame constants
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - show-ahead write FIFO with registered full/empty flags
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    logic [7:0]         mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [FIFO_AW:0]   count_next;
    logic               do_push;
    logic               do_pop;

    // Gating uses the registered flags, so a push into a full FIFO is refused
    // even when a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == (FIFO_AW+1)'(FIFO_DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with write FIFO and baud-tick driven FSM
module uart_tx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       clk_uart,
    input  logic [7:0] data_in,
    input  logic       wr_en,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    output logic       TXD,
    output logic       bps_en,
    output logic       interrupt
);

    uart_state_t state;
    logic [7:0]  shift_reg;
    logic [2:0]  bit_cnt;
    logic [7:0]  fifo_dout;
    logic        pop;

    assign pop = (state == ST_IDLE) && !empty;

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .FIFO_AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .RST   (RST),
        .push  (wr_en),
        .din   (data_in),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (RST) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            TXD       <= 1'b1;
            bps_en    <= 1'b0;
            interrupt <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            overflow  <= wr_en && full;
            interrupt <= 1'b0;
            case (state)
                ST_IDLE: begin
                    TXD    <= 1'b1;
                    bps_en <= 1'b0;
                    if (!empty) begin
                        shift_reg <= fifo_dout;
                        TXD       <= 1'b0;
                        bps_en    <= 1'b1;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (clk_uart) begin
                        TXD     <= shift_reg[0];
                        bit_cnt <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (clk_uart) begin
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            TXD   <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            TXD       <= shift_reg[1];
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    // Dropping bps_en here forces a 1-clk IDLE gap so the
                    // baud generator re-phases before the next start bit.
                    if (clk_uart) begin
                        interrupt <= 1'b1;
                        bps_en    <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
